// File: rtl/tms_boot_pkg.sv
// Shared types and constants for the TMS1x00 SPI-flash boot loader.
package tms_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_READ,
        ST_WRITE,
        ST_FINISH,
        ST_DONE
    } boot_state_t;

    localparam logic [7:0] SPI_READ_CMD = 8'h03;
    localparam int         WORD_BYTES   = 4;

    // Bytes arrive from flash as b0..b3 at [31:0] MSB-first; RAM wants b0 in the low lane.
    function automatic logic [31:0] pack_le(input logic [31:0] flash_order);
        return {flash_order[7:0], flash_order[15:8], flash_order[23:16], flash_order[31:24]};
    endfunction

endpackage

// File: rtl/tms_spi_shift.sv
// SPI mode-0 engine: SCK divider plus a 32-bit shift register that sends
// MSB first on MOSI and samples MISO into the LSB on every SCK rising edge.
module tms_spi_shift #(
    parameter int DIV = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        load,
    input  logic        len,
    input  logic        go,
    input  logic [31:0] din,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        bit_done,
    output logic        xfer_done,
    output logic [31:0] shift_q
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [31:0]   shreg;
    logic [DW-1:0] div_cnt;
    logic [5:0]    bits_left;
    logic          active;
    logic          wide;
    logic          half_end;
    logic          last_bit;

    assign half_end  = active && (div_cnt == DW'(DIV - 1));
    assign last_bit  = (bits_left == 6'd1);
    assign bit_done  = half_end && spi_sck;
    // Level flag for the final bit; the transfer completes on the bit_done that accompanies it.
    assign xfer_done = active && last_bit;
    assign shift_q   = shreg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shreg     <= '0;
            div_cnt   <= '0;
            bits_left <= '0;
            active    <= 1'b0;
            wide      <= 1'b0;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            if (load) begin
                shreg <= din;
            end else if (half_end && !spi_sck) begin
                shreg <= {shreg[30:0], spi_miso};
            end

            // A go on the final falling edge restarts seamlessly, so byte streams stay back to back.
            if (go) begin
                active    <= 1'b1;
                wide      <= len;
                bits_left <= len ? 6'd32 : 6'd8;
                div_cnt   <= '0;
                spi_sck   <= 1'b0;
                spi_mosi  <= (load && len) ? din[31] : 1'b0;
            end else if (half_end) begin
                div_cnt <= '0;
                spi_sck <= ~spi_sck;
                if (spi_sck) begin
                    bits_left <= bits_left - 6'd1;
                    if (last_bit) begin
                        active   <= 1'b0;
                        spi_mosi <= 1'b0;
                    end else begin
                        spi_mosi <= wide ? shreg[31] : 1'b0;
                    end
                end
            end else if (active) begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tms_rom_boot.sv
// Boot loader: streams the program image from SPI NOR flash (READ 0x03) into the
// shared program RAM one 32-bit word at a time, then raises done to release the CPU.
module tms_rom_boot
    import tms_boot_pkg::*;
#(
    parameter int          WORDS      = 512,
    parameter logic [23:0] FLASH_ADDR = 24'h000000,
    parameter int          DIV        = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        boot_en,
    output logic        spi_csb,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        ram_csb,
    output logic        ram_web,
    output logic [8:0]  ram_addr,
    output logic [3:0]  ram_wmask,
    output logic [31:0] ram_din,
    output logic        busy,
    output logic        done
);

    localparam logic [9:0] LAST_WORD = 10'(WORDS - 1);

    boot_state_t state;
    logic [9:0]  word_cnt;
    logic [1:0]  byte_cnt;
    logic        load;
    logic        len;
    logic        go;
    logic        bit_done;
    logic        xfer_done;
    logic        xfer_end;
    logic        last_word;
    logic        byte_last;
    logic [31:0] shift_q;

    assign ram_wmask = 4'b1111;
    assign xfer_end  = bit_done && xfer_done;
    assign last_word = (word_cnt == LAST_WORD);
    assign byte_last = (byte_cnt == 2'(WORD_BYTES - 1));

    always_comb begin
        load = 1'b0;
        len  = 1'b0;
        go   = 1'b0;
        case (state)
            ST_IDLE: begin
                load = boot_en;
                len  = boot_en;
                go   = boot_en;
            end
            ST_CMD:   go = xfer_end;
            ST_READ:  go = xfer_end && !byte_last;
            ST_WRITE: go = !last_word;
            default:  go = 1'b0;
        endcase
    end

    tms_spi_shift #(
        .DIV (DIV)
    ) u_shift (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .load      (load),
        .len       (len),
        .go        (go),
        .din       ({SPI_READ_CMD, FLASH_ADDR}),
        .spi_miso  (spi_miso),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .bit_done  (bit_done),
        .xfer_done (xfer_done),
        .shift_q   (shift_q)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            word_cnt <= '0;
            byte_cnt <= '0;
            spi_csb  <= 1'b1;
            ram_csb  <= 1'b1;
            ram_web  <= 1'b1;
            ram_addr <= '0;
            ram_din  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (boot_en) begin
                        state   <= ST_CMD;
                        spi_csb <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_CMD: begin
                    if (xfer_end) begin
                        state    <= ST_READ;
                        byte_cnt <= '0;
                    end
                end
                ST_READ: begin
                    // The shifter never reloads mid-word, so after byte 3 it holds b0..b3 in flash order.
                    if (xfer_end) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_last) begin
                            state    <= ST_WRITE;
                            ram_csb  <= 1'b0;
                            ram_web  <= 1'b0;
                            ram_addr <= word_cnt[8:0];
                            ram_din  <= pack_le(shift_q);
                        end
                    end
                end
                ST_WRITE: begin
                    ram_csb  <= 1'b1;
                    ram_web  <= 1'b1;
                    word_cnt <= word_cnt + 10'd1;
                    if (last_word) begin
                        state   <= ST_FINISH;
                        spi_csb <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state <= ST_READ;
                    end
                end
                ST_FINISH: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tms_rom_boot.sv
// Self-checking bench: three loader instances (small, slow/offset, full-size) against a shared flash model.
module tb_tms_rom_boot;

    localparam int NI = 3;

    logic            wb_clk_i;
    logic            wb_rst_i;
    logic            boot_en;
    logic [NI-1:0]   spi_csb;
    logic [NI-1:0]   spi_sck;
    logic [NI-1:0]   spi_mosi;
    logic [NI-1:0]   spi_miso;
    logic [NI-1:0]   ram_csb;
    logic [NI-1:0]   ram_web;
    logic [NI-1:0]   busy;
    logic [NI-1:0]   done;
    logic [8:0]      ram_addr  [NI];
    logic [3:0]      ram_wmask [NI];
    logic [31:0]     ram_din   [NI];

    int              checks;
    int              errors;
    int              cyc;
    int              done_cyc   [NI];
    int              done_drop  [NI];
    int              csb_after  [NI];
    int              overlap    [NI];
    int              wr_cnt     [NI];
    int              sck_wr_err [NI];
    int              rise_cnt   [NI];
    int              hi_len     [NI];
    int              hi_runs    [NI];
    int              hi_bad     [NI];
    logic            csb_fell   [NI];
    logic            prev_sck   [NI];
    logic [31:0]     cmd_word   [NI];
    logic [31:0]     wr_data    [NI][512];
    logic [8:0]      wr_addr    [NI][512];

    typedef struct {
        int          inst;
        int          idx;
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_vec_t;

    typedef struct {
        int          inst;
        logic [31:0] cmd;
        int          done_at;
        int          writes;
        int          sck_pulses;
    } run_vec_t;

    wr_vec_t  wr_tab  [8];
    run_vec_t run_tab [3];

    tms_rom_boot #(.WORDS(4), .FLASH_ADDR(24'h000000), .DIV(1)) u_boot0 (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i), .boot_en (boot_en),
        .spi_csb (spi_csb[0]), .spi_sck (spi_sck[0]), .spi_mosi (spi_mosi[0]), .spi_miso (spi_miso[0]),
        .ram_csb (ram_csb[0]), .ram_web (ram_web[0]), .ram_addr (ram_addr[0]), .ram_wmask (ram_wmask[0]),
        .ram_din (ram_din[0]), .busy (busy[0]), .done (done[0])
    );

    tms_rom_boot #(.WORDS(2), .FLASH_ADDR(24'h012340), .DIV(3)) u_boot1 (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i), .boot_en (boot_en),
        .spi_csb (spi_csb[1]), .spi_sck (spi_sck[1]), .spi_mosi (spi_mosi[1]), .spi_miso (spi_miso[1]),
        .ram_csb (ram_csb[1]), .ram_web (ram_web[1]), .ram_addr (ram_addr[1]), .ram_wmask (ram_wmask[1]),
        .ram_din (ram_din[1]), .busy (busy[1]), .done (done[1])
    );

    tms_rom_boot #(.WORDS(512), .FLASH_ADDR(24'h000000), .DIV(1)) u_boot2 (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i), .boot_en (boot_en),
        .spi_csb (spi_csb[2]), .spi_sck (spi_sck[2]), .spi_mosi (spi_mosi[2]), .spi_miso (spi_miso[2]),
        .ram_csb (ram_csb[2]), .ram_web (ram_web[2]), .ram_addr (ram_addr[2]), .ram_wmask (ram_wmask[2]),
        .ram_din (ram_din[2]), .busy (busy[2]), .done (done[2])
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    function automatic int div_of(input int g);
        return (g == 1) ? 3 : 1;
    endfunction

    // Flash image byte n holds n[7:0]; d indexes data bits after the command.
    function automatic logic flash_bit(input int d);
        logic [7:0] b;
        b = 8'(d / 8);
        return b[7 - (d % 8)];
    endfunction

    // Flash model and bus observer, sampled 1 time unit after every rising clock edge.
    always @(posedge wb_clk_i) begin
        #1;
        if (wb_rst_i) begin
            cyc = 0;
            for (int g = 0; g < NI; g++) begin
                done_cyc[g]   = 0;
                done_drop[g]  = 0;
                csb_after[g]  = 0;
                overlap[g]    = 0;
                wr_cnt[g]     = 0;
                sck_wr_err[g] = 0;
                rise_cnt[g]   = 0;
                hi_len[g]     = 0;
                hi_runs[g]    = 0;
                hi_bad[g]     = 0;
                csb_fell[g]   = 1'b0;
                prev_sck[g]   = 1'b0;
                cmd_word[g]   = '0;
                spi_miso[g]   = 1'b0;
            end
        end else begin
            cyc = cyc + 1;
            for (int g = 0; g < NI; g++) begin
                if (done[g] && done_cyc[g] == 0) done_cyc[g] = cyc;
                if (done_cyc[g] != 0 && !done[g]) done_drop[g]++;
                if (done_cyc[g] != 0 && !spi_csb[g]) csb_after[g]++;
                if (!spi_csb[g]) csb_fell[g] = 1'b1;
                if (busy[g] && done[g]) overlap[g]++;
                if (!ram_csb[g] && !ram_web[g]) begin
                    if (wr_cnt[g] < 512) begin
                        wr_data[g][wr_cnt[g]] = ram_din[g];
                        wr_addr[g][wr_cnt[g]] = ram_addr[g];
                    end
                    if (spi_sck[g]) sck_wr_err[g]++;
                    wr_cnt[g]++;
                end
                if (spi_csb[g]) begin
                    rise_cnt[g] = 0;
                    hi_len[g]   = 0;
                    spi_miso[g] = 1'b0;
                end else if (spi_sck[g] && !prev_sck[g]) begin
                    if (rise_cnt[g] < 32) cmd_word[g] = {cmd_word[g][30:0], spi_mosi[g]};
                    rise_cnt[g]++;
                    hi_len[g] = 1;
                end else if (spi_sck[g]) begin
                    hi_len[g]++;
                end else if (prev_sck[g]) begin
                    hi_runs[g]++;
                    if (hi_len[g] != div_of(g)) hi_bad[g]++;
                    if (rise_cnt[g] >= 32) spi_miso[g] = flash_bit(rise_cnt[g] - 32);
                end
                prev_sck[g] = spi_sck[g];
            end
        end
    end

    task automatic apply_stimulus(input logic rst, input logic en);
        wb_rst_i = rst;
        boot_en  = en;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        wr_tab[0] = '{0, 0,   9'd0,   32'h03020100};
        wr_tab[1] = '{0, 1,   9'd1,   32'h07060504};
        wr_tab[2] = '{0, 2,   9'd2,   32'h0B0A0908};
        wr_tab[3] = '{0, 3,   9'd3,   32'h0F0E0D0C};
        wr_tab[4] = '{1, 0,   9'd0,   32'h03020100};
        wr_tab[5] = '{1, 1,   9'd1,   32'h07060504};
        wr_tab[6] = '{2, 0,   9'd0,   32'h03020100};
        wr_tab[7] = '{2, 511, 9'd511, 32'hFFFEFDFC};

        run_tab[0] = '{0, 32'h03000000, 326,   4,   160};
        run_tab[1] = '{1, 32'h03012340, 580,   2,   96};
        run_tab[2] = '{2, 32'h03000000, 33346, 512, 16416};

        apply_stimulus(1'b1, 1'b0);
        repeat (3) @(negedge wb_clk_i);

        check_output("reset_spi",    {29'd0, spi_csb[0], spi_sck[0], spi_mosi[0]}, 32'h4);
        check_output("reset_ram_en", {30'd0, ram_csb[0], ram_web[0]}, 32'h3);
        check_output("reset_addr",   {23'd0, ram_addr[0]}, 32'h0);
        check_output("reset_din",    ram_din[0], 32'h0);
        check_output("reset_status", {30'd0, busy[0], done[0]}, 32'h0);
        check_output("wmask",        {28'd0, ram_wmask[0]}, 32'hF);

        $display("[TB] skip load");
        apply_stimulus(1'b0, 1'b0);
        repeat (20) @(negedge wb_clk_i);
        check_output("skip_done_cycle", 32'(done_cyc[0]), 32'd2);
        check_output("skip_done_held",  {31'd0, done[0]}, 32'd1);
        check_output("skip_csb_fell",   {31'd0, csb_fell[0]}, 32'd0);
        check_output("skip_writes",     32'(wr_cnt[0]), 32'd0);
        check_output("skip_busy",       {31'd0, busy[0]}, 32'd0);

        $display("[TB] full load on all instances");
        apply_stimulus(1'b1, 1'b1);
        repeat (3) @(negedge wb_clk_i);
        apply_stimulus(1'b0, 1'b1);
        for (int i = 0; i < 40000 && !done[2]; i++) @(negedge wb_clk_i);
        check_output("load_timeout", {31'd0, done[2]}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            int g;
            g = run_tab[i].inst;
            check_output($sformatf("cmd_word_%0d", g),   cmd_word[g], run_tab[i].cmd);
            check_output($sformatf("done_cycle_%0d", g), 32'(done_cyc[g]), 32'(run_tab[i].done_at));
            check_output($sformatf("write_count_%0d", g), 32'(wr_cnt[g]), 32'(run_tab[i].writes));
            check_output($sformatf("sck_pulses_%0d", g), 32'(hi_runs[g]), 32'(run_tab[i].sck_pulses));
            check_output($sformatf("sck_high_len_%0d", g), 32'(hi_bad[g]), 32'd0);
            check_output($sformatf("sck_in_write_%0d", g), 32'(sck_wr_err[g]), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("wr_addr_%0d_%0d", wr_tab[i].inst, wr_tab[i].idx),
                         {23'd0, wr_addr[wr_tab[i].inst][wr_tab[i].idx]}, {23'd0, wr_tab[i].addr});
            check_output($sformatf("wr_data_%0d_%0d", wr_tab[i].inst, wr_tab[i].idx),
                         wr_data[wr_tab[i].inst][wr_tab[i].idx], wr_tab[i].data);
        end

        check_output("busy_done_overlap", 32'(overlap[0] + overlap[1] + overlap[2]), 32'd0);

        $display("[TB] hold after full-size load");
        repeat (1000) @(negedge wb_clk_i);
        check_output("big_done_held",  {31'd0, done[2]}, 32'd1);
        check_output("big_done_drop",  32'(done_drop[2]), 32'd0);
        check_output("big_csb_after",  32'(csb_after[2]), 32'd0);
        check_output("big_no_extra_wr", 32'(wr_cnt[2]), 32'd512);

        $display("[TB] reset during word 1 byte 2");
        apply_stimulus(1'b1, 1'b1);
        repeat (3) @(negedge wb_clk_i);
        apply_stimulus(1'b0, 1'b1);
        for (int i = 0; i < 1000 && wr_cnt[0] < 1; i++) @(negedge wb_clk_i);
        check_output("mid_first_write", 32'(wr_cnt[0]), 32'd1);
        repeat (40) @(negedge wb_clk_i);
        check_output("mid_pre_busy", {30'd0, busy[0], spi_csb[0]}, 32'h2);
        apply_stimulus(1'b1, 1'b1);
        @(negedge wb_clk_i);
        check_output("mid_reset_outputs", {28'd0, spi_csb[0], ram_csb[0], busy[0], spi_sck[0]}, 32'hC);
        apply_stimulus(1'b0, 1'b1);
        for (int i = 0; i < 2000 && !done[0]; i++) @(negedge wb_clk_i);
        check_output("reload_done_cycle", 32'(done_cyc[0]), 32'd326);
        check_output("reload_writes",     32'(wr_cnt[0]), 32'd4);
        check_output("reload_word0_addr", {23'd0, wr_addr[0][0]}, 32'd0);
        check_output("reload_word0_data", wr_data[0][0], 32'h03020100);
        check_output("reload_word3_data", wr_data[0][3], 32'h0F0E0D0C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tms_rom_boot.md
# tms_rom_boot

Upstream boot loader for the TMS1x00 core. After reset it streams the program image from an external SPI NOR flash using READ 0x03 and packs the bytes into 32-bit words. It writes those words into the shared program RAM through the RAM write port, then raises `done`, which the top level uses to release the CPU from reset.

## Interface
Parameters:
- `WORDS`, default 512: number of 32-bit words loaded. Must be 1–512; 512 words is the full 2048-byte / 11-bit program space.
- `FLASH_ADDR`, default 24'h000000: flash byte address of image byte 0.
- `DIV`, default 2: SCK half-period in clock cycles. Must be ≥1.

Ports:
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: reset, synchronous and active-high.
- `boot_en` in 1: sampled in IDLE. 1 = load image; 0 = skip the load.
- `spi_csb` out 1: flash chip select, active low.
- `spi_sck` out 1: flash clock, SPI mode 0 (idles low).
- `spi_mosi` out 1: command/address to flash, MSB first.
- `spi_miso` in 1: data from flash. External pad sync is done upstream of this block.
- `ram_csb` out 1: RAM select, active low.
- `ram_web` out 1: RAM write enable, active low.
- `ram_addr` out 9: word address.
- `ram_wmask` out 4: constant 4'b1111.
- `ram_din` out 32: write data.
- `busy` out 1: high while a load is in progress.
- `done` out 1: high once the image is loaded or skipped; holds until reset.

## Operation
- States: IDLE → CMD → READ ⇄ WRITE → FINISH → DONE.
- **Reset values:**
  - `spi_csb`=1, `spi_sck`=0, `spi_mosi`=0
  - `ram_csb`=1, `ram_web`=1, `ram_addr`=0, `ram_din`=0
  - `busy`=0, `done`=0
  - word counter 0, byte counter 0
- **IDLE:** lasts one cycle after reset release.
  - `boot_en`=0 → DONE.
  - `boot_en`=1 → CMD: `spi_csb`=0, `busy`=1.
- **CMD:** shift the 32-bit word {8'h03, FLASH_ADDR} out MSB first.
  - MOSI is updated while SCK is low.
  - SCK is low for DIV cycles, then high for DIV cycles, per bit.
  - After bit 0 → READ.
- **READ:** sample MISO on each SCK rising edge, MSB first, 8 bits per byte.
  - Byte k of the current word lands in `ram_din[8k+7:8k]` (little-endian; flash order b0..b3).
  - After the 4th byte → WRITE.
- **WRITE:** exactly one cycle with `ram_csb`=0, `ram_web`=0, `ram_addr`=word counter, `ram_din` = the assembled word.
  - SCK is held low, and `spi_csb` stays low, so the flash stream is only paused.
  - Next cycle: `ram_csb`=`ram_web`=1 and the word counter increments.
  - If the written word was word WORDS-1 → FINISH; otherwise → READ.
- **FINISH:** `spi_csb`=1, `busy`=0 → DONE.
- **DONE:** `done`=1, all other outputs idle; terminal until reset.
- `ram_wmask` is tied to 4'b1111; only full-word writes are performed.
- The word counter is 10 bits, so WORDS=512 terminates correctly with no wrap to 0.
- **Reset mid-load:** every output returns to its reset value on the same edge.
  - `spi_csb` rising aborts the flash READ.
  - RAM contents are left partial; `done`=0 keeps the CPU in reset.
  - The load restarts from word 0 after reset release.

## Timing
- MOSI and MISO are registered. MISO is sampled on the clock edge at which SCK rises.
- Command phase: 64·DIV cycles.
- Each word: 64·DIV cycles of SCK, plus 1 WRITE cycle.
- Total cycles from reset deassert to `done`=1: 2 + 64·DIV + WORDS·(64·DIV+1). Example: WORDS=4, DIV=1 gives 326.
- The RAM write strobe is a single-cycle pulse; the write is committed on that edge.
- `busy` and `done` are never high at the same time.

## Structure
- Package `tms_boot_pkg`:
  - state enum (IDLE, CMD, READ, WRITE, FINISH, DONE)
  - `SPI_READ_CMD` = 8'h03
  - `WORD_BYTES` = 4
- Sub-module `tms_spi_shift`: SCK divider plus a bidirectional 8/32-bit shift register. It takes `load`, `len`, and `go`, and returns `bit_done`/`xfer_done` and the shift contents.
- The top-level FSM, byte/word counters and word packing stay in `tms_rom_boot`.

## Test plan
- **Full load, DIV=1, WORDS=4:** flash model returns bytes 00..0F.
  - MOSI carries 0x03000000.
  - RAM receives 03020100, 07060504, 0B0A0908, 0F0E0D0C at addresses 0–3.
  - `done` rises at cycle 326.
- **Skip:** `boot_en`=0 at reset release → `done`=1 at cycle 2, `spi_csb` never falls, no RAM write.
- **Non-zero base:** FLASH_ADDR=24'h012340, DIV=3.
  - Command shifted is 0x03012340.
  - Each SCK half-period is 3 cycles.
  - SCK is low during every WRITE cycle.
- **Reset mid-operation:** assert `wb_rst_i` during byte 2 of word 1.
  - Next edge: `spi_csb`=1, `ram_csb`=1, `busy`=0.
  - After release, the reload writes word 0 again with the correct data.
- **Boundary, WORDS=512:**
  - Last write goes to `ram_addr`=511; no write to address 0 after it.
  - `done` holds high for 1000 further cycles.
  - `spi_csb` stays high once loading ends.
